wrr_burst_arbiter: RTL

- Weighted round-robin arbiter with burst locking.
- Shares one downstream resource (bus, FIFO write port) among N requesters.
- The winner keeps the grant until its burst ends (last beat) and for up to weight bursts, then the grant rotates.
- Sits between the requester masters and the shared resource's valid/ready port.
- Grants are registered, unlike the purely combinational round-robin/priority arbiters.

---
 rtl/wrr_burst_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter that locks the grant for whole bursts, up to weight bursts per turn
module wrr_burst_arbiter #(
  parameter int N     = 4,
  parameter int WGT_W = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req_i,
  input  logic [N-1:0]       last_i,
  input  logic [N*WGT_W-1:0] weight_i,
  input  logic               ready_i,
  output logic [N-1:0]       gnt_o,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             r_state, w_state;
  logic [N-1:0]       r_gnt, w_gnt;
  logic [IDX_W-1:0]   r_idx, w_idx, r_ptr, w_ptr, w_hi, w_lo, w_win;
  logic [WGT_W-1:0]   r_credit, w_credit, w_wgt, w_dec;
  logic               w_any_hi, w_req, w_eob, w_release;
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_any_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) w_lo = IDX_W'(i);
      if (req_i[i] && i >= int'(r_ptr)) begin
        w_hi     = IDX_W'(i);
        w_any_hi = 1'b1;
      end
    end
    w_win = w_any_hi ? w_hi : w_lo;
    w_wgt = weight_i[w_win*WGT_W +: WGT_W];
  end
  // Only the granted requester's handshake matters while locked.
  assign w_req     = req_i[r_idx];
  assign w_eob     = w_req & ready_i & last_i[r_idx];
  assign w_dec     = (r_credit == '0) ? '0 : r_credit - WGT_W'(1);
  assign w_release = !w_req || (w_eob && w_dec == '0);
  always_comb begin
    w_state  = r_state;
    w_gnt    = r_gnt;
    w_idx    = r_idx;
    w_ptr    = r_ptr;
    w_credit = r_credit;
    if (r_state == IDLE) begin
      if (|req_i) begin
        w_state  = GRANT;
        w_gnt    = N'(1) << w_win;
        w_idx    = w_win;
        w_credit = (w_wgt == '0) ? WGT_W'(1) : w_wgt;
      end
    end else begin
      w_credit = w_eob ? w_dec : r_credit;
      if (w_release) begin
        w_state = IDLE;
        w_gnt   = '0;
        w_idx   = '0;
        w_ptr   = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      r_state  <= w_state;
      r_gnt    <= w_gnt;
      r_idx    <= w_idx;
      r_ptr    <= w_ptr;
      r_credit <= w_credit;
    end
  end
  assign gnt_o       = r_gnt;
  assign gnt_valid_o = |r_gnt;
  assign gnt_idx_o   = r_idx;
endmodule
